// File: rtl/pool_pkg.sv
// Shared definitions for the streaming 2-D pooling engine: FSM encoding,
// pooling-mode constants and the window shift / accumulator width helpers.
package pool_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // A KxK window sums K*K samples, so averaging shifts by log2(K*K).
    function automatic int pool_shift(input int k);
        return 2 * $clog2(k);
    endfunction

    function automatic int pool_sum_width(input int dw, input int k);
        return dw + pool_shift(k);
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: horizontal accumulator, per-window-column partial buffer,
// max/sum combine and output register. Optional ReLU clamp under POOL_RELU_EN.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int POOL_K     = 2,
    parameter int NUM_COLS   = 3,
    parameter int COL_W      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_accept,
    input  logic                  i_mode,
    input  logic                  i_first_x,
    input  logic                  i_last_x,
    input  logic                  i_first_y,
    input  logic                  i_last_y,
    input  logic [COL_W-1:0]      i_col,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int SHIFT = pool_shift(POOL_K);
    localparam int SW    = pool_sum_width(DATA_WIDTH, POOL_K);

    logic signed [SW-1:0]         acc_q;
    logic signed [SW-1:0]         col_q [NUM_COLS];
    logic signed [SW-1:0]         px_ext;
    logic signed [SW-1:0]         hsum_d;
    logic signed [SW-1:0]         csum_d;
    logic signed [DATA_WIDTH-1:0] res_d;
    logic signed [DATA_WIDTH-1:0] o_data_q;

    function automatic logic signed [SW-1:0] combine(
        input logic             mode,
        input logic signed [SW-1:0] a,
        input logic signed [SW-1:0] b
    );
        if (mode == MODE_AVG) return a + b;
        return (a > b) ? a : b;
    endfunction

    // Arithmetic shift gives floor division for negative sums too.
    function automatic logic signed [DATA_WIDTH-1:0] floor_avg(input logic signed [SW-1:0] s);
        return DATA_WIDTH'(s >>> SHIFT);
    endfunction

`ifdef POOL_RELU_EN
    function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? '0 : v;
    endfunction
`endif

    always_comb begin
        px_ext = {{(SW-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
        hsum_d = i_first_x ? px_ext : combine(i_mode, acc_q, px_ext);
        csum_d = i_first_y ? hsum_d : combine(i_mode, col_q[i_col], hsum_d);
        res_d  = (i_mode == MODE_AVG) ? floor_avg(csum_d) : DATA_WIDTH'(csum_d);
`ifdef POOL_RELU_EN
        res_d  = relu(res_d);
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q    <= '0;
            o_data_q <= '0;
            for (int i = 0; i < NUM_COLS; i++) col_q[i] <= '0;
        end else if (i_accept) begin
            acc_q <= hsum_d;
            if (i_last_x) col_q[i_col] <= csum_d;
            if (i_last_x && i_last_y) o_data_q <= res_d;
        end
    end

    assign o_data = o_data_q;

endmodule

// File: rtl/pool2d_stream.sv
// Streaming KxK max/average pooling over raster-order frames, CHANNELS lanes
// sharing one FSM and x/y counters. Define POOL_RELU_EN to clamp negative results.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 6,
    parameter int IMG_HEIGHT = 6,
    parameter int POOL_K     = 2,
    parameter int CHANNELS   = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_mode,
    input  logic                           i_valid,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
    output logic                           o_valid,
    output logic [DATA_WIDTH*CHANNELS-1:0] o_data,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int KB = $clog2(POOL_K);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int NC = IMG_WIDTH / POOL_K;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    if (!(POOL_K == 2 || POOL_K == 4) || (IMG_WIDTH % POOL_K) != 0 ||
        (IMG_HEIGHT % POOL_K) != 0) begin : g_bad_cfg
        $error("pool2d_stream: POOL_K must be 2 or 4 and divide IMG_WIDTH and IMG_HEIGHT");
    end

    state_t         state_q, state_d;
    logic           mode_q;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           valid_q, done_q;

    logic           accept;
    logic           last_col, last_row;
    logic           first_x, last_x, first_y, last_y;
    logic [CW-1:0]  col_idx;

    assign accept   = (state_q == ST_RUN) && i_valid;
    assign last_col = (x_q == XW'(IMG_WIDTH - 1));
    assign last_row = (y_q == YW'(IMG_HEIGHT - 1));
    assign first_x  = (x_q[KB-1:0] == '0);
    assign last_x   = &x_q[KB-1:0];
    assign first_y  = (y_q[KB-1:0] == '0);
    assign last_y   = &y_q[KB-1:0];
    assign col_idx  = CW'(x_q >> KB);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        x_d = '0;
                        y_d = last_row ? '0 : y_q + 1'b1;
                        if (last_row) state_d = ST_IDLE;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_MAX;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            // Mode is latched only when a frame actually starts.
            if (state_q == ST_IDLE && i_start) mode_q <= i_mode;
            valid_q <= accept && last_x && last_y;
            done_q  <= accept && last_col && last_row;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pool_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .POOL_K    (POOL_K),
            .NUM_COLS  (NC),
            .COL_W     (CW)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_accept (accept),
            .i_mode   (mode_q),
            .i_first_x(first_x),
            .i_last_x (last_x),
            .i_first_y(first_y),
            .i_last_y (last_y),
            .i_col    (col_idx),
            .i_data   (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_data   (o_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign o_valid = valid_q;
    assign o_done  = done_q;
    assign o_busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: a 4x4/K=2 single-lane instance and an
// 8x8/K=4 two-lane instance, driven from hand-computed vectors.
module tb_pool2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_start, a_mode, a_valid;
    logic [15:0] a_data;
    logic        a_ovalid, a_busy, a_done;
    logic [15:0] a_odata;

    logic        b_start, b_mode, b_valid;
    logic [31:0] b_data;
    logic        b_ovalid, b_busy, b_done;
    logic [31:0] b_odata;

    pool2d_stream #(
        .DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_K(2), .CHANNELS(1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_mode(a_mode),
        .i_valid(a_valid), .i_data(a_data), .o_valid(a_ovalid),
        .o_data(a_odata), .o_busy(a_busy), .o_done(a_done)
    );

    pool2d_stream #(
        .DATA_WIDTH(16), .IMG_WIDTH(8), .IMG_HEIGHT(8), .POOL_K(4), .CHANNELS(2)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_mode(b_mode),
        .i_valid(b_valid), .i_data(b_data), .o_valid(b_ovalid),
        .o_data(b_odata), .o_busy(b_busy), .o_done(b_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] a_q_data[$];
    int          a_q_cyc[$];
    int          a_exp_cyc[$];
    int          a_done_cnt = 0;
    int          a_done_err = 0;
    int          a_last_done_cyc = 0;

    logic [31:0] b_q_data[$];
    int          b_done_cnt = 0;

    always @(negedge clk) begin
        if (a_ovalid === 1'b1) begin
            a_q_data.push_back(a_odata);
            a_q_cyc.push_back(cyc);
        end
        if (a_done === 1'b1) begin
            a_done_cnt      <= a_done_cnt + 1;
            a_last_done_cyc <= cyc;
            if (a_ovalid !== 1'b1) a_done_err <= a_done_err + 1;
        end
        if (b_ovalid === 1'b1) b_q_data.push_back(b_odata);
        if (b_done === 1'b1) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic a_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            a_valid = 1'b0;
            a_start = 1'b0;
        end
    endtask

    // Start pulse, then 16 raster pixels; mode is flipped after the start cycle
    // and an optional stray start is raised mid-frame, neither of which may matter.
    task automatic a_frame(input logic mode, input logic [15:0] pix[16],
                           input bit gaps, input bit poke);
        @(posedge clk); #1;
        a_start = 1'b1;
        a_mode  = mode;
        a_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            a_mode  = ~mode;
            if (i == 0) chk("busy_run", {31'd0, a_busy}, 32'd1);
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    a_valid = 1'b0;
                    a_data  = 16'h7FFF;
                    @(posedge clk); #1;
                end
            end
            a_valid = 1'b1;
            a_data  = pix[i];
            if (poke && i == 8) begin
                a_start = 1'b1;
                a_mode  = ~mode;
            end
            if (((i % 4) % 2 == 1) && ((i / 4) % 2 == 1)) a_exp_cyc.push_back(cyc + 1);
        end
    endtask

    task automatic a_verify(input string tag, input int qb, input int eb, input int n,
                            input logic [15:0] exp[8]);
        chk({tag, "_cnt"}, a_q_data.size() - qb, n);
        for (int k = 0; k < n; k++) begin
            if (qb + k < a_q_data.size()) begin
                chk({tag, "_data"}, {16'd0, a_q_data[qb + k]}, {16'd0, exp[k]});
                chk({tag, "_lat"}, a_q_cyc[qb + k], a_exp_cyc[eb + k]);
            end
        end
        chk({tag, "_done_cyc"}, a_last_done_cyc, a_exp_cyc[a_exp_cyc.size() - 1]);
    endtask

    logic [15:0] ramp[16];
    logic [15:0] neg5[16];
    logic [15:0] exp8[8];
    logic [15:0] b_exp0[4];
    logic [15:0] b_exp1[4];
    int qb, eb, db;

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_mode = 1'b0; a_valid = 1'b0; a_data = '0;
        b_start = 1'b0; b_mode = 1'b0; b_valid = 1'b0; b_data = '0;
        for (int i = 0; i < 16; i++) begin
            ramp[i] = 16'(i + 1);
            neg5[i] = 16'hFFFB;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_done",  {31'd0, a_done},   32'd0);
        chk("rst_busy",  {31'd0, a_busy},   32'd0);
        chk("rst_data",  {16'd0, a_odata},  32'd0);
        chk("rst_b_data", b_odata, 32'd0);
        rst = 1'b0;

        // Max frame, then an average frame started on the max frame's done cycle.
        qb = a_q_data.size(); eb = a_exp_cyc.size(); db = a_done_cnt;
        a_frame(1'b0, ramp, 1'b0, 1'b0);
        a_frame(1'b1, ramp, 1'b0, 1'b0);
        a_idle(3);
        exp8 = '{16'd6, 16'd8, 16'd14, 16'd16, 16'd3, 16'd5, 16'd11, 16'd13};
        a_verify("maxavg", qb, eb, 8, exp8);
        chk("maxavg_done", a_done_cnt - db, 2);
        chk("busy_idle", {31'd0, a_busy}, 32'd0);

        // All -5 in max mode.
        qb = a_q_data.size(); eb = a_exp_cyc.size(); db = a_done_cnt;
        a_frame(1'b0, neg5, 1'b0, 1'b0);
        a_idle(3);
`ifdef POOL_RELU_EN
        exp8 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
`else
        exp8 = '{16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB, 16'h0, 16'h0, 16'h0, 16'h0};
`endif
        a_verify("neg5", qb, eb, 4, exp8);
        chk("neg5_done", a_done_cnt - db, 1);

        // Random valid gaps and a stray start/mode change mid-frame.
        qb = a_q_data.size(); eb = a_exp_cyc.size(); db = a_done_cnt;
        a_frame(1'b0, ramp, 1'b1, 1'b1);
        a_idle(3);
        exp8 = '{16'd6, 16'd8, 16'd14, 16'd16, 16'd0, 16'd0, 16'd0, 16'd0};
        a_verify("gaps", qb, eb, 4, exp8);
        chk("gaps_done", a_done_cnt - db, 1);

        // Reset after 7 pixels, then valid without start, then a clean frame.
        qb = a_q_data.size(); db = a_done_cnt;
        @(posedge clk); #1;
        a_start = 1'b1; a_mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            a_valid = 1'b1;
            a_data  = ramp[i];
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_rst_data",  {16'd0, a_odata},  32'd0);
        chk("abort_rst_busy",  {31'd0, a_busy},   32'd0);
        chk("abort_rst_valid", {31'd0, a_ovalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a_valid = 1'b1;
            a_data  = 16'(100 + i);
        end
        a_idle(3);
        chk("abort_outs", a_q_data.size() - qb, 1);
        chk("abort_done", a_done_cnt - db, 0);
        chk("idle_valid_busy", {31'd0, a_busy}, 32'd0);

        qb = a_q_data.size(); eb = a_exp_cyc.size(); db = a_done_cnt;
        a_frame(1'b0, ramp, 1'b0, 1'b0);
        a_idle(3);
        exp8 = '{16'd6, 16'd8, 16'd14, 16'd16, 16'd0, 16'd0, 16'd0, 16'd0};
        a_verify("fresh", qb, eb, 4, exp8);
        chk("fresh_done", a_done_cnt - db, 1);
        chk("done_with_valid_err", a_done_err, 0);

        // Two lanes, 8x8, K=4, average; lane0 = x+8y-20, lane1 = -lane0.
        db = b_done_cnt;
        @(posedge clk); #1;
        b_start = 1'b1; b_mode = 1'b1;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                int v;
                @(posedge clk); #1;
                b_start = 1'b0;
                b_mode  = 1'b0;
                b_valid = 1'b1;
                v = x + 8 * y - 20;
                b_data = {16'(-v), 16'(v)};
            end
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef POOL_RELU_EN
        b_exp0 = '{16'd0, 16'd0, 16'd25, 16'd29};
        b_exp1 = '{16'd6, 16'd2, 16'd0, 16'd0};
`else
        b_exp0 = '{16'hFFF9, 16'hFFFD, 16'd25, 16'd29};
        b_exp1 = '{16'd6, 16'd2, 16'hFFE6, 16'hFFE2};
`endif
        chk("b_cnt", b_q_data.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < b_q_data.size()) begin
                chk("b_lane0", {16'd0, b_q_data[k][15:0]},  {16'd0, b_exp0[k]});
                chk("b_lane1", {16'd0, b_q_data[k][31:16]}, {16'd0, b_exp1[k]});
            end
        end
        chk("b_done", b_done_cnt - db, 1);
        chk("b_busy_idle", {31'd0, b_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
